vu_bar_renderer: RTL
====================

Name: vu_bar_renderer

Overview:
- Upstream pixel source for the ILI9341 frame-buffer driver. It supplies one RGB565 pixel per driver request, in raster order, for a two-channel vertical VU meter.
- Latches left/right audio levels, double-buffers them at frame boundaries (no tearing), and maintains per-channel peak-hold with decay.
- No RAM: each pixel is computed on the fly from scan position and latched levels.

Parameters:
BAR_L_X, 40, left bar first column (0..239)
BAR_R_X, 140, right bar first column
BAR_W, 60, bar width in columns; bars must not overlap or exceed column 239
HOLD_FRAMES, 30, frames a new peak is held before decay starts (8-bit)
DECAY, 2, peak decrement per frame after hold expires (8-bit)

Ports:
clk  in  1  system clock, same clock as TFT driver
reset_n  in  1  synchronous active-low reset
level_l  in  8  left level, 0..255
level_r  in  8  right level, 0..255
level_valid  in  1  one-cycle strobe; captures level_l/level_r into shadow registers
fb_clk  in  1  driver pixel request; rising edge = advance to next pixel
fb_start  in  1  driver frame-boundary pulse (one cycle)
pixel_data  out  16  RGB565 pixel for driver
px_x  out  8  column of pixel currently on pixel_data (0..239)
px_y  out  9  row of pixel currently on pixel_data (0..319, 0 = top)

Behaviour:
- Reset (reset_n=0 at clk edge): pixel_data=0, px_x=0, px_y=0. Shadow levels, active levels, peaks, hold counters and fb_clk_q are all 0. Next-position counters are (0,0).
- Edge detect: fb_clk_q <= fb_clk each cycle; rise = fb_clk & !fb_clk_q. fb_clk high/low phases are each >=4 clk; no other handshake.
- Rise in cycle N, at the edge ending N:
  - pixel_data <= colour(next_x, next_y); px_x/px_y <= next_x/next_y.
  - Next position advances: x 239 -> 0 with y+1; (239,319) -> (0,0).
  - Latency is 1 clk from rise. pixel_data holds until the next rise, which covers both driver byte slots.
- Colour(x,y), using ybot = 319 - y:
  - Outside both bar column ranges [BAR_x, BAR_x+BAR_W): 0x0000.
  - Inside a bar: h = lvl + (lvl>>2) (10-bit; max 318), computed from that channel's active level. ph is computed the same way from that channel's peak.
  - Priority 1: if peak>0 and (ybot==ph or ybot==ph+1) -> 0xFFFF (marker).
  - Priority 2: else if ybot<h -> 0x07E0 if ybot<192; 0xFFE0 if ybot<272; else 0xF800.
  - Priority 3: else 0x2104 (unlit track).
- level_valid: shadow_l/r <= level_l/r. Active levels are unchanged.
- fb_start in cycle N, at the edge ending N:
  - active_l/r <= shadow_l/r.
  - Next position <= (0,0); this wins over any simultaneous increment.
  - Per channel, using the shadow value s:
    - if s >= peak: peak <= s, hold <= HOLD_FRAMES
    - else if hold>0: hold <= hold-1
    - else: peak <= (peak>DECAY) ? peak-DECAY : 0
- Simultaneous events:
  - rise + fb_start in the same cycle: that pixel is rendered at the old position with old active levels and old peaks; next position becomes (0,0).
  - level_valid + fb_start in the same cycle: active gets the old shadow; shadow gets the new sample.
- Reset mid-frame: all state clears. The first rise after reset returns pixel (0,0) in colour 0x0000, or 0x2104 if a bar covers column 0.
- Free-running without fb_start: position wraps (239,319) -> (0,0) by counting alone.

Test Plan:
- Reset, then 3 fb_clk rises (levels 0) -> px (0,0),(1,0),(2,0); pixel_data 0x0000; each update exactly 1 clk after the rise.
- level_l=255, level_r=0, level_valid, then fb_start, then a full 76800-pixel frame:
  - x=40 rows 1..319 (ybot 318..0) -> red/yellow/green split at ybot 272/192.
  - ybot 318 white.
  - Right bar all 0x2104.
- Peak hold: level_l 200 for one frame, then 0:
  - peak stays 200 for 30 fb_starts, then 198,196,...
  - Marker row at ph = 250 (y=69,68).
  - Saturates at 0 and the marker disappears.
- fb_start asserted with fb_clk rise mid-frame at (100,50) -> that pixel reports (100,50); the following rise reports (0,0).
- level_valid and fb_start same cycle (old shadow 10, new 80) -> frame uses 10; next fb_start applies 80.
- reset_n low at (17,200) mid-frame -> pixel_data=0, px=(0,0); peaks and levels are 0 in the following frame.

Source files
------------

// File: rtl/vu_bar_renderer.sv
// -----------------------------------------------------------------------------
// vu_bar_renderer
//
// Pixel source for the ILI9341 frame-buffer driver. It draws a two-channel
// vertical VU meter. Each driver request returns one RGB565 pixel in raster
// order. No frame memory is used: every pixel is computed from the scan
// position and the latched levels.
//
// Ports:
//   clk          system clock, shared with the TFT driver
//   reset_n      synchronous active-low reset
//   level_l/r    8-bit channel levels, captured on level_valid
//   level_valid  one-cycle strobe loading the shadow level registers
//   fb_clk       driver pixel request; each rising edge advances one pixel
//   fb_start     driver frame-boundary pulse; applies the shadow levels,
//                updates the peak-hold state and rewinds the scan to (0,0)
//   pixel_data   RGB565 pixel for the position on px_x/px_y
//   px_x, px_y   column (0..239) and row (0..319, 0 = top) of pixel_data
// -----------------------------------------------------------------------------
module vu_bar_renderer #(
   parameter int unsigned BAR_L_X     = 40,
   parameter int unsigned BAR_R_X     = 140,
   parameter int unsigned BAR_W       = 60,
   parameter logic [7:0]  HOLD_FRAMES = 8'd30,
   parameter logic [7:0]  DECAY       = 8'd2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [7:0]  level_l,
   input  logic [7:0]  level_r,
   input  logic        level_valid,
   input  logic        fb_clk,
   input  logic        fb_start,
   output logic [15:0] pixel_data,
   output logic [7:0]  px_x,
   output logic [8:0]  px_y
);

   localparam logic [8:0] LeftLo  = 9'(BAR_L_X);
   localparam logic [8:0] LeftHi  = 9'(BAR_L_X + BAR_W);
   localparam logic [8:0] RightLo = 9'(BAR_R_X);
   localparam logic [8:0] RightHi = 9'(BAR_R_X + BAR_W);

   localparam logic [15:0] ColBlack  = 16'h0000;
   localparam logic [15:0] ColGreen  = 16'h07E0;
   localparam logic [15:0] ColYellow = 16'hFFE0;
   localparam logic [15:0] ColRed    = 16'hF800;
   localparam logic [15:0] ColWhite  = 16'hFFFF;
   localparam logic [15:0] ColTrack  = 16'h2104;

   // Index 0 is the left channel, index 1 the right channel.
   logic [1:0][7:0] shadow_q, active_q, peak_q, peak_d, hold_q, hold_d;

   logic        fb_clk_q;
   logic        rise;
   logic [7:0]  next_x_q;
   logic [8:0]  next_y_q;
   logic [8:0]  ybot;
   logic        in_l, in_r;
   logic [15:0] colour_d;
   logic [15:0] pixel_q;
   logic [7:0]  px_x_q;
   logic [8:0]  px_y_q;

   assign rise = fb_clk & ~fb_clk_q;
   assign ybot = 9'd319 - next_y_q;
   assign in_l = ({1'b0, next_x_q} >= LeftLo) && ({1'b0, next_x_q} < LeftHi);
   assign in_r = ({1'b0, next_x_q} >= RightLo) && ({1'b0, next_x_q} < RightHi);

   // Bar height is level * 1.25, so a full-scale level reaches row 318 from the bottom.
   function automatic logic [15:0] bar_colour(input logic [8:0] yb9,
                                              input logic [7:0] lvl,
                                              input logic [7:0] pk);
      logic [9:0]  h, ph, yb;
      logic [15:0] col;
      h   = {2'b00, lvl} + {4'b0000, lvl[7:2]};
      ph  = {2'b00, pk} + {4'b0000, pk[7:2]};
      yb  = {1'b0, yb9};
      col = ColTrack;
      if ((pk != 8'd0) && ((yb == ph) || (yb == ph + 10'd1))) begin
         col = ColWhite;
      end else if (yb < h) begin
         if (yb < 10'd192) begin
            col = ColGreen;
         end else if (yb < 10'd272) begin
            col = ColYellow;
         end else begin
            col = ColRed;
         end
      end
      return col;
   endfunction

   always_comb begin
      colour_d = ColBlack;
      if (in_l) begin
         colour_d = bar_colour(ybot, active_q[0], peak_q[0]);
      end else if (in_r) begin
         colour_d = bar_colour(ybot, active_q[1], peak_q[1]);
      end
   end

   // Peak-hold update applied at each frame boundary, compared against the
   // shadow value that is about to become active.
   always_comb begin
      peak_d = peak_q;
      hold_d = hold_q;
      for (int c = 0; c < 2; c++) begin
         if (shadow_q[c] >= peak_q[c]) begin
            peak_d[c] = shadow_q[c];
            hold_d[c] = HOLD_FRAMES;
         end else if (hold_q[c] != 8'd0) begin
            hold_d[c] = hold_q[c] - 8'd1;
         end else if (peak_q[c] > DECAY) begin
            peak_d[c] = peak_q[c] - DECAY;
         end else begin
            peak_d[c] = 8'd0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         fb_clk_q <= 1'b0;
         next_x_q <= '0;
         next_y_q <= '0;
         pixel_q  <= '0;
         px_x_q   <= '0;
         px_y_q   <= '0;
         shadow_q <= '0;
         active_q <= '0;
         peak_q   <= '0;
         hold_q   <= '0;
      end else begin
         fb_clk_q <= fb_clk;

         if (rise) begin
            pixel_q <= colour_d;
            px_x_q  <= next_x_q;
            px_y_q  <= next_y_q;
         end

         // A frame boundary rewinds the scan even if a request lands in the same cycle.
         if (fb_start) begin
            next_x_q <= '0;
            next_y_q <= '0;
         end else if (rise) begin
            if (next_x_q == 8'd239) begin
               next_x_q <= '0;
               next_y_q <= (next_y_q == 9'd319) ? 9'd0 : next_y_q + 9'd1;
            end else begin
               next_x_q <= next_x_q + 8'd1;
            end
         end

         if (level_valid) begin
            shadow_q <= {level_r, level_l};
         end

         if (fb_start) begin
            active_q <= shadow_q;
            peak_q   <= peak_d;
            hold_q   <= hold_d;
         end
      end
   end

   assign pixel_data = pixel_q;
   assign px_x       = px_x_q;
   assign px_y       = px_y_q;

endmodule
